// File: rtl/speed_frame_rx.sv
// speed_frame_rx: 8N1 UART receiver that decodes A5/high/low speed frames.
// Define SPEED_RX_CHECKSUM_EN to add a trailing XOR checksum byte to each frame.
module speed_frame_rx #(
    parameter int SYS_FREQ    = 50000000,
    parameter int BAUD        = 9600,
    parameter int WIDTH_SPEED = 14
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   serial_data_in,
    output logic [WIDTH_SPEED-1:0] speed,
    output logic                   speed_valid,
    output logic                   frame_err
);
    localparam int CPB = SYS_FREQ / BAUD;
    localparam int TO  = 20 * CPB;
    localparam int CW  = $clog2(TO + 1);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_t;
`ifdef SPEED_RX_CHECKSUM_EN
    typedef enum logic [1:0] {HUNT, HI, LO, CHK} pr_t;
    logic [7:0] lo_q;
`else
    typedef enum logic [1:0] {HUNT, HI, LO} pr_t;
`endif
    rx_t                   rx_q;
    pr_t                   pr_q;
    logic                  sync1_q, sync2_q, prev_q;
    logic [CW-1:0]         cnt_q, to_q;
    logic [2:0]            bit_q;
    logic [7:0]            sh_q, hi_q;
    logic [WIDTH_SPEED-1:0] speed_q;
    logic                  valid_q, err_q;
    logic                  fall, tick_half, tick_bit, byte_ok, byte_bad, hi_ok, timeout;
    assign fall      = prev_q & ~sync2_q;
    assign tick_half = cnt_q == CW'(CPB / 2 - 1);
    assign tick_bit  = cnt_q == CW'(CPB - 1);
    assign byte_ok   = rx_q == STOP && tick_bit && sync2_q;
    assign byte_bad  = rx_q == STOP && tick_bit && !sync2_q;
    assign hi_ok     = (sh_q >> (WIDTH_SPEED - 8)) == 8'd0;
    // Idle time is measured from the stop sample, since leaving STOP clears to_q.
    assign timeout   = pr_q != HUNT && rx_q == IDLE && !fall && to_q == CW'(TO - 1);
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            rx_q    <= IDLE;
            pr_q    <= HUNT;
            cnt_q   <= '0;
            to_q    <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            hi_q    <= '0;
`ifdef SPEED_RX_CHECKSUM_EN
            lo_q    <= '0;
`endif
            speed_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync1_q <= serial_data_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= cnt_q + 1'b1;
            to_q    <= (rx_q == IDLE && pr_q != HUNT) ? to_q + 1'b1 : '0;
            case (rx_q)
                IDLE: if (fall) begin
                    rx_q  <= START;
                    cnt_q <= '0;
                end
                START: if (tick_half) begin
                    rx_q  <= sync2_q ? IDLE : DATA;
                    cnt_q <= '0;
                end
                DATA: if (tick_bit) begin
                    sh_q  <= {sync2_q, sh_q[7:1]};
                    bit_q <= bit_q + 1'b1;
                    cnt_q <= '0;
                    if (bit_q == 3'd7) rx_q <= STOP;
                end
                STOP: if (tick_bit) rx_q <= IDLE;
            endcase
            if (timeout || (byte_bad && pr_q != HUNT)) begin
                err_q <= 1'b1;
                pr_q  <= HUNT;
            end else if (byte_ok) begin
                case (pr_q)
                    HUNT: if (sh_q == 8'hA5) pr_q <= HI;
                    HI: begin
                        hi_q  <= sh_q;
                        pr_q  <= hi_ok ? LO : HUNT;
                        err_q <= !hi_ok;
                    end
`ifdef SPEED_RX_CHECKSUM_EN
                    LO: begin
                        lo_q <= sh_q;
                        pr_q <= CHK;
                    end
                    CHK: begin
                        if (sh_q == (8'hA5 ^ hi_q ^ lo_q)) begin
                            speed_q <= WIDTH_SPEED'({hi_q, lo_q});
                            valid_q <= 1'b1;
                        end else err_q <= 1'b1;
                        pr_q <= HUNT;
                    end
`else
                    LO: begin
                        speed_q <= WIDTH_SPEED'({hi_q, sh_q});
                        valid_q <= 1'b1;
                        pr_q    <= HUNT;
                    end
`endif
                    default: pr_q <= HUNT;
                endcase
            end
        end
    end
    assign speed       = speed_q;
    assign speed_valid = valid_q;
    assign frame_err   = err_q;
endmodule

// File: doc/speed_frame_rx.md
SPEED_FRAME_RX -- requirements
Module: speed_frame_rx

Interface
REQ-001 The block SHALL have parameter SYS_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 9600, serial bit rate; CLKS_PER_BIT = SYS_FREQ/BAUD (5208 at defaults).
REQ-003 The block SHALL have parameter WIDTH_SPEED, default 14, width of the decoded speed.
REQ-004 The block SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port serial_data_in, input, 1, asynchronous UART line (8N1, LSB first, idle high), driven by the speed unit's serial_data_out.
REQ-007 The block SHALL have port speed, output, WIDTH_SPEED, the last valid decoded speed.
REQ-008 The block SHALL have port speed_valid, output, 1, one-cycle pulse when speed updates.
REQ-009 The block SHALL have port frame_err, output, 1, one-cycle pulse on any discarded frame.

Function
REQ-010 serial_data_in SHALL pass through a two-flop synchronizer (reset value 1) before use; all latencies are measured from the synchronized signal.
REQ-011 The bit receiver SHALL use states IDLE, START, DATA, STOP; IDLE->START on synchronized falling edge.
REQ-012 In START the line SHALL be re-sampled after CLKS_PER_BIT/2 cycles; high -> back to IDLE with no error (glitch), low -> DATA.
REQ-013 In DATA eight bits SHALL be sampled every CLKS_PER_BIT cycles from the start mid-point, LSB first; then STOP.
REQ-014 In STOP the line SHALL be sampled one bit period after the last data bit; high -> byte accepted, low -> framing error; either way return to IDLE the next cycle.
REQ-015 The frame parser SHALL use states HUNT, HI, LO, CHK; frame = 0xA5 header, speed high byte, speed low byte, checksum byte.
REQ-016 HUNT SHALL ignore every accepted byte other than 0xA5 without flagging an error; 0xA5 -> HI.
REQ-017 In HI, high-byte bits 7 down to WIDTH_SPEED-8 SHALL be zero; otherwise frame_err pulses and the parser returns to HUNT.
REQ-018 Checksum SHALL equal XOR of header, high and low bytes; match -> speed loads and speed_valid pulses; mismatch -> frame_err pulses, speed keeps its old value; both return to HUNT.
REQ-019 speed and speed_valid SHALL update in the cycle after the final byte's stop-bit sample cycle.
REQ-020 A framing error in HI, LO or CHK SHALL pulse frame_err and return the parser to HUNT; a framing error in HUNT SHALL be silent.
REQ-021 Inter-byte timeout: in HI, LO or CHK, if no start edge occurs within 20*CLKS_PER_BIT cycles after the previous stop sample, frame_err SHALL pulse and the parser SHALL return to HUNT.
REQ-022 speed_valid and frame_err SHALL never assert in the same cycle.

Reset
REQ-023 While reset is high, the next clock edge SHALL set both FSMs to IDLE/HUNT, clear all counters and shift registers, set speed=0, speed_valid=0, frame_err=0, and synchronizer flops=1.
REQ-024 Reset asserted mid-byte or mid-frame SHALL discard the partial data with no error pulse.

Configuration
REQ-025 With macro SPEED_RX_CHECKSUM_EN defined, the frame SHALL be 4 bytes and be checked per REQ-018.
REQ-026 Without SPEED_RX_CHECKSUM_EN, the frame SHALL be 3 bytes (no CHK state); speed loads after the low byte, and frame_err arises only from REQ-017, REQ-020 and REQ-021.

Verification
REQ-027 Bytes A5 00 F0 55 at 9600 baud with the macro defined -> speed=240, one speed_valid pulse, no frame_err.
REQ-028 Bytes A5 00 F0 54 -> one frame_err pulse, speed unchanged from the prior value, no speed_valid.
REQ-029 A 1000-cycle low glitch while idle, then a valid frame -> no error, and the frame decodes correctly.
REQ-030 A5 sent, then the line held high for 25 bit times -> frame_err pulses at 20*CLKS_PER_BIT cycles; a following valid frame decodes.
REQ-031 A5 followed by a byte with stop bit low -> frame_err pulses once; bytes 3C A5 00 F0 55 -> 0x3C ignored and speed=240.
REQ-032 Reset pulsed mid-frame after A5 00 -> outputs zero; the trailing F0 55 is ignored with no pulses.
